div_nr: RTL

DIV_NR -- requirements
Module: div_nr

---
 rtl/div_nr_if.sv | 15 +
 rtl/div_nr.sv | 102 ++++++++++
 2 files changed

// File: rtl/div_nr_if.sv
// Handshake and operand/result bus for the non-restoring divider.
interface div_nr_if #(parameter int WIDTH = 32);
    logic             bgn;
    logic             sgn;
    logic [WIDTH-1:0] ibusA;
    logic [WIDTH-1:0] ibusB;
    logic [WIDTH-1:0] obusA;
    logic [WIDTH-1:0] obusB;
    logic             fin;
    logic             dz;
    logic             ovf;

    modport master (output bgn, sgn, ibusA, ibusB, input obusA, obusB, fin, dz, ovf);
    modport slave  (input bgn, sgn, ibusA, ibusB, output obusA, obusB, fin, dz, ovf);
endinterface

// File: rtl/div_nr.sv
// Iterative non-restoring divider: one quotient bit per cycle on magnitudes,
// then a remainder fix-up and sign application before a one-cycle result strobe.
module div_nr #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_b,
    div_nr_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

    state_t           st;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, dz_c, ovf_c;
    logic             fin, dz, ovf;

    logic             a_neg, b_neg, sub;
    logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
    logic [WIDTH:0]   p_sh, add_a, add_b, sum, p_fix;

    assign a_neg = bus.sgn & bus.ibusA[WIDTH-1];
    assign b_neg = bus.sgn & bus.ibusB[WIDTH-1];
    assign a_mag = a_neg ? -bus.ibusA : bus.ibusA;
    assign b_mag = b_neg ? -bus.ibusB : bus.ibusB;

    // One adder serves iteration add/sub and the final remainder fix-up.
    assign p_sh  = {p[WIDTH-1:0], q[WIDTH-1]};
    assign sub   = (st == ITER) & ~p[WIDTH];
    assign add_a = (st == CORR) ? p : p_sh;
    assign add_b = sub ? ~{1'b0, d} : {1'b0, d};
    assign sum   = add_a + add_b + (WIDTH+1)'(sub);

    assign p_fix = p[WIDTH] ? sum : p;
    // With a zero divisor P accumulates |A|, so re-signing restores A exactly.
    assign q_fin = dz_c ? '1 : (q_neg ? -q : q);
    assign r_fin = r_neg ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st    <= IDLE;
            p     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz_c  <= 1'b0;
            ovf_c <= 1'b0;
            fin   <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.bgn) begin
                    p     <= '0;
                    q     <= a_mag;
                    d     <= b_mag;
                    cnt   <= '0;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    dz_c  <= (bus.ibusB == '0);
                    ovf_c <= bus.sgn & (bus.ibusA == MIN_NEG) & (bus.ibusB == '1);
                    st    <= ITER;
                end
                ITER: begin
                    p   <= sum;
                    q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) st <= CORR;
                end
                CORR: begin
                    q   <= q_fin;
                    p   <= {1'b0, r_fin};
                    fin <= 1'b1;
                    dz  <= dz_c;
                    ovf <= ovf_c;
                    st  <= DONE;
                end
                DONE: begin
                    fin <= 1'b0;
                    dz  <= 1'b0;
                    ovf <= 1'b0;
                    st  <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.fin   = fin;
    assign bus.dz    = dz;
    assign bus.ovf   = ovf;
    assign bus.obusA = fin ? q : {WIDTH{1'bz}};
    assign bus.obusB = fin ? p[WIDTH-1:0] : {WIDTH{1'bz}};
endmodule
